// File: rtl/msk_affine_pipe_if.sv
// Handshake/data bundle for msk_affine_pipe.
// slave  : the pipe side (consumes ina/inb/op, produces out/occupancy).
// master : the producer/consumer side driving the pipe.
// Layout : share s of lane l sits at bit s*count+l of ina/inb/out;
//          lane l's opcode sits at op[2l+1:2l].
interface msk_affine_pipe_if #(
  parameter int d      = 2,
  parameter int count  = 8,
  parameter int STAGES = 2
);
  localparam int OW = $clog2(STAGES+1);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [2*count-1:0]   op;
  logic [count*d-1:0]   ina;
  logic [count*d-1:0]   inb;
  logic                 out_valid;
  logic                 out_ready;
  logic [count*d-1:0]   out;
  logic [OW-1:0]        occupancy;

  modport slave (
    input  flush, in_valid, op, ina, inb, out_ready,
    output in_ready, out_valid, out, occupancy
  );

  modport master (
    output flush, in_valid, op, ina, inb, out_ready,
    input  in_ready, out_valid, out, occupancy
  );
endinterface

// File: rtl/msk_affine_pipe.sv
// Pipelined masked affine lane array.
// Each lane computes XOR / XNOR / A / NOT A share-wise on d-share sharings,
// then results move through STAGES valid/ready register stages.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : msk_affine_pipe_if.slave (flush, in_valid/in_ready, op, ina,
//              inb, out_valid/out_ready, out, occupancy)

// One lane: share-wise combine; the complement only touches share 0 so the
// unmasked value is inverted while the mask shares stay untouched.
module msk_affine_lane #(
  parameter int d = 2
) (
  input  logic [1:0]   i_op,
  input  logic [d-1:0] i_a,
  input  logic [d-1:0] i_b,
  output logic [d-1:0] o_t
);
  logic [d-1:0] w_x;

  assign w_x = i_a ^ ({d{~i_op[1]}} & i_b);
  assign o_t = w_x ^ {{(d-1){1'b0}}, i_op[0]};
endmodule

module msk_affine_pipe #(
  parameter int d      = 2,
  parameter int count  = 8,
  parameter int STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  msk_affine_pipe_if.slave bus
);
  localparam int W  = count*d;
  localparam int OW = $clog2(STAGES+1);

  logic [count-1:0][d-1:0]  w_la, w_lb, w_lt;
  logic [W-1:0]             w_t;
  logic [STAGES-1:0]        r_vld;
  logic [STAGES-1:0][W-1:0] r_data;
  logic [STAGES-1:0]        w_adv;
  logic [STAGES-1:0]        w_vsrc;
  logic [STAGES-1:0][W-1:0] w_dsrc;
  logic [OW-1:0]            r_occ;
  logic                     w_acc, w_del;

  // Regroup the share-major bus into per-lane share vectors and back.
  for (genvar l = 0; l < count; l++) begin : g_lane
    for (genvar s = 0; s < d; s++) begin : g_sh
      assign w_la[l][s]      = bus.ina[s*count+l];
      assign w_lb[l][s]      = bus.inb[s*count+l];
      assign w_t[s*count+l]  = w_lt[l][s];
    end
    msk_affine_lane #(.d(d)) u_lane (
      .i_op (bus.op[2*l+1:2*l]),
      .i_a  (w_la[l]),
      .i_b  (w_lb[l]),
      .o_t  (w_lt[l])
    );
  end

  // A stage may load when it is empty or the stage after it moves;
  // accumulated from the output end so bubbles compress.
  always_comb begin
    logic acc;
    acc   = bus.out_ready;
    w_adv = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      acc      = ~r_vld[k] | acc;
      w_adv[k] = acc;
    end
  end

  always_comb begin
    w_vsrc    = '0;
    w_dsrc    = '0;
    w_vsrc[0] = bus.in_valid;
    w_dsrc[0] = w_t;
    for (int k = 1; k < STAGES; k++) begin
      w_vsrc[k] = r_vld[k-1];
      w_dsrc[k] = r_data[k-1];
    end
  end

  assign bus.in_ready  = w_adv[0] & ~bus.flush;
  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.out       = r_data[STAGES-1];
  assign bus.occupancy = r_occ;

  assign w_acc = bus.in_valid & bus.in_ready;
  assign w_del = r_vld[STAGES-1] & bus.out_ready;

  // Flush only drops valid bits; data registers keep their last contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_data <= '0;
      r_occ  <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (bus.flush)    r_vld[k] <= 1'b0;
        else if (w_adv[k]) r_vld[k] <= w_vsrc[k];
        if (w_adv[k] && !bus.flush) r_data[k] <= w_dsrc[k];
      end
      if (bus.flush) r_occ <= '0;
      else           r_occ <= r_occ + OW'(w_acc) - OW'(w_del);
    end
  end
endmodule

// File: tb/tb_msk_affine_pipe.sv
module tb_msk_affine_pipe;
  localparam int D = 2, C = 4, S = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msk_affine_pipe_if #(.d(D), .count(C), .STAGES(S)) bus ();
  msk_affine_pipe #(.d(D), .count(C), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] d;
    logic [7:0] op;
    logic [3:0] ua, ub;
    int         pos;   // pipeline position, S-1 = presented at output
  } ent_t;
  ent_t q[$];

  typedef struct {
    string      nm;
    logic [7:0] op, a, b, exp;
  } vec_t;

  int n_pass = 0, n_tot = 0;
  logic last_acc, last_del, last_rdy, last_ovld;
  logic [7:0] last_out;
  logic [1:0] last_occ;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Share-level expectation from the opcode rules.
  function automatic logic [7:0] f_ref(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int l = 0; l < C; l++)
      for (int s = 0; s < D; s++)
        r[s*C+l] = a[s*C+l] ^ (op[2*l+1] ? 1'b0 : b[s*C+l]) ^ ((s == 0) ? op[2*l] : 1'b0);
    return r;
  endfunction

  function automatic logic [3:0] unm(input logic [7:0] x);
    return x[3:0] ^ x[7:4];
  endfunction

  // Boolean meaning of each opcode on unmasked values.
  function automatic logic [3:0] f_plain(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int l = 0; l < C; l++)
      case (op[2*l+:2])
        2'd0: r[l] = a[l] ^ b[l];
        2'd1: r[l] = ~(a[l] ^ b[l]);
        2'd2: r[l] = a[l];
        default: r[l] = ~a[l];
      endcase
    return r;
  endfunction

  // Inputs are set at a negedge; sample at +2, update the model at posedge.
  task automatic tick();
    logic er, ev;
    int prev, np;
    ent_t e;
    #2;
    er = !bus.flush && (q.size() < S || bus.out_ready);
    ev = (q.size() > 0) && (q[0].pos == S-1);
    chk("in_ready", bus.in_ready, er);
    chk("out_valid", bus.out_valid, ev);
    chk("occupancy", bus.occupancy, q.size());
    if (ev) chk("out_data", bus.out, q[0].d);
    last_acc  = bus.in_valid && er;
    last_del  = ev && bus.out_ready;
    last_rdy  = bus.in_ready;
    last_ovld = bus.out_valid;
    last_out  = bus.out;
    last_occ  = bus.occupancy;
    if (last_del) chk("unmasked", unm(bus.out), f_plain(q[0].op, q[0].ua, q[0].ub));
    @(posedge clk);
    if (last_del) void'(q.pop_front());
    if (bus.flush) q.delete();
    else begin
      prev = S;
      foreach (q[i]) begin
        np = q[i].pos + 1;
        if (np > prev-1) np = prev-1;
        q[i].pos = np;
        prev = np;
      end
      if (last_acc) begin
        e.d = f_ref(bus.op, bus.ina, bus.inb); e.op = bus.op;
        e.ua = unm(bus.ina); e.ub = unm(bus.inb); e.pos = 0;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  // Single transaction into an empty pipe; checks data and latency.
  task automatic run_one(input string nm, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp);
    int lat;
    bus.out_ready = 1'b1; bus.flush = 1'b0;
    bus.op = op; bus.ina = a; bus.inb = b; bus.in_valid = 1'b1;
    tick();
    chk({nm, "_accept"}, last_rdy, 1'b1);
    bus.in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      tick();
      if (last_ovld) begin
        lat = c;
        chk({nm, "_out"}, last_out, exp);
      end
    end
    chk({nm, "_latency"}, lat, S);
  endtask

  vec_t vt[4];
  int n_acc, n_del;

  initial begin
    vt[0] = '{"xor",   8'h00,        8'h6A, 8'h03, 8'h69};
    vt[1] = '{"xnor",  8'h55,        8'h6A, 8'h03, 8'h66};
    vt[2] = '{"mixed", 8'b11100100,  8'h0C, 8'h03, 8'h05};
    vt[3] = '{"mixm",  8'b11100100,  8'hF3, 8'hA5, 8'hD8};

    rst = 1'b1;
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0;
    bus.op = '0; bus.ina = '0; bus.inb = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_occupancy", bus.occupancy, 0);
    chk("rst_out", bus.out, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    foreach (vt[i]) run_one(vt[i].nm, vt[i].op, vt[i].a, vt[i].b, vt[i].exp);

    // Backpressure: 5 offered, only S fit while the output stalls.
    bus.out_ready = 1'b0; n_acc = 0; n_del = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1; bus.op = 8'h1B;
      bus.ina = 8'h31 + 8'(n_acc * 7); bus.inb = 8'h5C ^ 8'(n_acc);
      tick();
      if (last_acc) n_acc++;
    end
    chk("bp_accepts", n_acc, S);
    chk("bp_occupancy", last_occ, S);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && (n_acc < 5 || q.size() > 0); c++) begin
      bus.in_valid = (n_acc < 5);
      bus.ina = 8'h31 + 8'(n_acc * 7); bus.inb = 8'h5C ^ 8'(n_acc);
      tick();
      if (last_acc) n_acc++;
      if (last_del) n_del++;
    end
    chk("bp_delivered", n_del, 5);

    // Flush with two in flight.
    bus.out_ready = 1'b0; n_acc = 0;
    for (int c = 0; c < 6 && n_acc < 2; c++) begin
      bus.in_valid = 1'b1; bus.op = 8'hAA; bus.ina = 8'h90 + 8'(n_acc); bus.inb = 8'h0F;
      tick();
      if (last_acc) n_acc++;
    end
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    tick();
    chk("flush_in_ready", last_rdy, 1'b0);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    tick();
    chk("flush_occupancy", last_occ, 0);
    chk("flush_out_valid", last_ovld, 1'b0);
    bus.out_ready = 1'b1;
    repeat (4) tick();

    // Asynchronous reset between edges while streaming.
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1; bus.op = 8'($urandom); bus.ina = 8'($urandom); bus.inb = 8'($urandom);
      tick();
    end
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_occupancy", bus.occupancy, 0);
    chk("arst_out", bus.out, 8'h00);
    rst = 1'b0; bus.in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    run_one("post_rst", 8'h00, 8'h6A, 8'h03, 8'h69);

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.out_ready = $urandom_range(0, 2) != 0;
      bus.flush     = $urandom_range(0, 15) == 0;
      bus.op = 8'($urandom); bus.ina = 8'($urandom); bus.inb = 8'($urandom);
      tick();
    end
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (S+2) tick();
    chk("drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
